// File: rtl/frame_buffer_pp.sv
// frame_buffer_pp: double-buffered (ping-pong) frame store.
//
// One bank is filled pixel by pixel from an internal write counter while the
// other bank, which holds the last complete frame, serves random-access reads.
// When the last pixel of a frame is written, the banks swap. frame_done
// pulses for one cycle and frame_valid goes high.
//
// Ports:
//   clk          - single clock, all logic on the rising edge
//   rst          - synchronous active-high reset (memory contents are kept)
//   in_enable    - write strobe, one pixel per high cycle
//   in_data      - pixel to write
//   rd_enable    - read request
//   rd_addr      - pixel index within the read bank
//   out_ready    - out_data valid strobe
//   out_data     - read pixel (0 when out of range or no frame is stored yet)
//   frame_done   - one-cycle pulse per completed frame
//   frame_valid  - high once at least one complete frame is stored
//   wr_bank      - bank currently being written
//
// Build option:
//   FRAME_BUFFER_PP_OUTREG_EN - adds an output register stage. Read latency
//   becomes 2 cycles and out_ready is delayed to match. Throughput stays at
//   one result per cycle.

module frame_buffer_pp #(
  parameter int unsigned color_width = 8,
  parameter int unsigned im_width    = 320,
  parameter int unsigned im_height   = 240,
  parameter int unsigned addr_width  = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_enable,
  input  logic [color_width-1:0] in_data,
  input  logic                   rd_enable,
  input  logic [addr_width-1:0]  rd_addr,
  output logic                   out_ready,
  output logic [color_width-1:0] out_data,
  output logic                   frame_done,
  output logic                   frame_valid,
  output logic                   wr_bank
);

  localparam int unsigned Depth = im_width * im_height;
  // One extra bit addresses the second bank.
  localparam int unsigned PhysW = addr_width + 1;
  localparam logic [addr_width-1:0] LastIdx    = addr_width'(Depth - 1);
  localparam logic [PhysW-1:0]      BankOffset = PhysW'(Depth);

  logic [color_width-1:0] mem_q [2*Depth];

  logic [addr_width-1:0]  wr_cnt_q, wr_cnt_d;
  logic                   wr_bank_q, wr_bank_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic                   rd_ready_q, rd_ready_d;
  logic [color_width-1:0] rd_data_q, rd_data_d;

  logic [PhysW-1:0] wr_pa;
  logic [PhysW-1:0] rd_pa;

  // Physical address = bank * Depth + index. Reads always target the bank
  // not being written, so a read never meets a write to the same word.
  always_comb begin
    wr_pa = wr_bank_q ? BankOffset + PhysW'(wr_cnt_q) : PhysW'(wr_cnt_q);
    rd_pa = wr_bank_q ? PhysW'(rd_addr) : BankOffset + PhysW'(rd_addr);
  end

  // Write side: counter, bank swap and frame status.
  always_comb begin
    wr_cnt_d      = wr_cnt_q;
    wr_bank_d     = wr_bank_q;
    frame_valid_d = frame_valid_q;
    frame_done_d  = 1'b0;
    if (in_enable) begin
      if (wr_cnt_q == LastIdx) begin
        wr_cnt_d      = '0;
        wr_bank_d     = ~wr_bank_q;
        frame_valid_d = 1'b1;
        frame_done_d  = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
  end

  // Read side: bank and frame_valid are the values before this edge, so a
  // swap on the same edge does not redirect the read.
  always_comb begin
    rd_ready_d = rd_enable;
    rd_data_d  = rd_data_q;
    if (rd_enable) begin
      if (frame_valid_q && (rd_addr <= LastIdx)) begin
        rd_data_d = mem_q[rd_pa];
      end else begin
        rd_data_d = '0;
      end
    end
  end

  // Storage is never cleared; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && in_enable) begin
      mem_q[wr_pa] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q      <= '0;
      wr_bank_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      rd_ready_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      wr_cnt_q      <= wr_cnt_d;
      wr_bank_q     <= wr_bank_d;
      frame_valid_q <= frame_valid_d;
      frame_done_q  <= frame_done_d;
      rd_ready_q    <= rd_ready_d;
      rd_data_q     <= rd_data_d;
    end
  end

`ifdef FRAME_BUFFER_PP_OUTREG_EN
  logic                   out_ready_q;
  logic [color_width-1:0] out_data_q;

  // The extra stage keeps its data when idle, like the first stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ready_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_ready_q <= rd_ready_q;
      if (rd_ready_q) begin
        out_data_q <= rd_data_q;
      end
    end
  end

  assign out_ready = out_ready_q;
  assign out_data  = out_data_q;
`else
  assign out_ready = rd_ready_q;
  assign out_data  = rd_data_q;
`endif

  assign frame_done  = frame_done_q;
  assign frame_valid = frame_valid_q;
  assign wr_bank     = wr_bank_q;

endmodule

// File: doc/frame_buffer_pp.md
FRAME_BUFFER_PP -- requirements
Module: frame_buffer_pp

Interface
REQ-001 The block SHALL expose parameter color_width, default 8, bits per pixel.
REQ-002 The block SHALL expose parameter im_width, default 320, pixels per line.
REQ-003 The block SHALL expose parameter im_height, default 240, lines per frame.
REQ-004 The block SHALL expose parameter addr_width, default 17, read/write address width; 2^addr_width >= im_width*im_height.
REQ-005 Port clk, input, 1, single clock; all logic rising-edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port in_enable, input, 1, write strobe; one pixel per high cycle.
REQ-008 Port in_data, input, color_width, pixel to write.
REQ-009 Port rd_enable, input, 1, read request.
REQ-010 Port rd_addr, input, addr_width, pixel index in the read bank.
REQ-011 Port out_ready, output, 1, out_data valid strobe.
REQ-012 Port out_data, output, color_width, read pixel.
REQ-013 Port frame_done, output, 1, one-cycle pulse per completed frame.
REQ-014 Port frame_valid, output, 1, high once at least one complete frame is stored.
REQ-015 Port wr_bank, output, 1, bank currently being written.

Function
REQ-016 Storage SHALL be two banks of DEPTH = im_width*im_height words; physical address = bank*DEPTH + index.
REQ-017 Writes SHALL use an internal counter wr_cnt, not an external address; on in_enable, mem[wr_bank][wr_cnt] <= in_data and wr_cnt increments.
REQ-018 When in_enable with wr_cnt = DEPTH-1: wr_cnt -> 0, wr_bank toggles, frame_valid -> 1, frame_done = 1 on the next cycle only.
REQ-019 in_enable low SHALL hold wr_cnt, wr_bank and memory unchanged.
REQ-020 Reads SHALL target bank ~wr_bank as sampled in the rd_enable cycle; a swap on that same edge does not affect the read.
REQ-021 Read latency SHALL be 1 cycle: rd_enable at cycle N -> out_ready = 1 and out_data valid at N+1.
REQ-022 rd_addr >= DEPTH, or frame_valid = 0, SHALL return out_data = 0 with out_ready = 1.
REQ-023 rd_enable low SHALL give out_ready = 0 next cycle, with out_data holding its last value.
REQ-024 Back-to-back rd_enable SHALL sustain one result per cycle, in request order.
REQ-025 Reads and writes never share a bank, so no read-during-write hazard SHALL exist.

Reset
REQ-026 On rst: wr_cnt = 0, wr_bank = 0, frame_valid = 0, frame_done = 0, out_ready = 0, out_data = 0.
REQ-027 Memory contents SHALL NOT be cleared.
REQ-028 Reset mid-frame SHALL discard the partial frame; writing restarts at bank 0, index 0.
REQ-029 Reset SHALL override in_enable and rd_enable in the same cycle.

Configuration
REQ-030 Macro FRAME_BUFFER_PP_OUTREG_EN defined: adds an output register stage; read latency = 2 cycles; out_ready is delayed to match; throughput remains 1/cycle.
REQ-031 Macro undefined: latency per REQ-021; reset values are identical in both builds.

Verification
REQ-032 Reset, read addr 5 before any full frame -> out_ready = 1 at N+1 with out_data = 0, frame_valid = 0.
REQ-033 Write 76800 pixels, data = index mod 256 -> frame_done pulse 1 cycle after the last write, wr_bank = 1, frame_valid = 1; read addr 300 -> 0x2C.
REQ-034 During the second frame write, read addrs 0..9 back-to-back -> 0x00..0x09 at 1 result/cycle, unaffected by the concurrent writes.
REQ-035 Read addr 76800 -> out_data = 0, out_ready = 1.
REQ-036 Assert rst after 1000 second-frame writes -> wr_bank = 0, frame_valid = 0; next write goes to bank 0 index 0.
REQ-037 With FRAME_BUFFER_PP_OUTREG_EN, rerun REQ-033 read -> 0x2C at N+2, out_ready low at N+1.
